// File: rtl/crc16_rx_checker.sv
// rtl/crc16_rx_checker.sv - SD DAT-line CRC16 receive checker for 1/4/8 lanes.
module crc16_rx_checker #(
  parameter int NumLanes = 4,
  parameter int LenWidth = 13
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     sd_clk_en_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [1:0]               bus_width_i,
  input  logic [LenWidth-1:0]      block_len_i,
  input  logic [NumLanes-1:0]      dat_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     crc_ok_o,
  output logic [NumLanes-1:0]      crc_err_o,
  output logic [16*NumLanes-1:0]   crc_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC,
    ST_DONE
  } state_e;

  state_e                     r_state;
  state_e                     w_next;
  logic [LenWidth-1:0]        r_cnt;
  logic [3:0]                 r_idx;
  logic [NumLanes-1:0]        r_act;
  logic [NumLanes-1:0][15:0]  r_crc;
  logic [NumLanes-1:0]        r_err;
  logic                       r_ok;
  logic                       r_done;

  logic [3:0]                 w_lanes;
  logic [NumLanes-1:0]        w_act_mask;
  logic [NumLanes-1:0]        w_bit_err;
  logic                       w_last_crc;

  function automatic logic [15:0] f_crc_step(input logic [15:0] c, input logic d);
    return {c[14:0], 1'b0} ^ ((d ^ c[15]) ? 16'h1021 : 16'h0000);
  endfunction

  // Requested width clamps to the lanes physically present.
  always_comb begin
    w_lanes = 4'(NumLanes);
    case (bus_width_i)
      2'd0:    w_lanes = 4'd1;
      2'd1:    w_lanes = 4'd4;
      2'd2:    w_lanes = 4'd8;
      default: w_lanes = 4'(NumLanes);
    endcase
    if (w_lanes > 4'(NumLanes)) w_lanes = 4'(NumLanes);
    w_act_mask = '0;
    for (int l = 0; l < NumLanes; l++) begin
      w_act_mask[l] = (4'(l) < w_lanes);
    end
  end

  always_comb begin
    w_bit_err = '0;
    for (int l = 0; l < NumLanes; l++) begin
      w_bit_err[l] = r_act[l] & (dat_i[l] ^ r_crc[l][r_idx]);
    end
  end

  assign w_last_crc = (r_state == ST_CRC) && sd_clk_en_i && (r_idx == 4'd0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_next = (block_len_i == '0) ? ST_CRC : ST_DATA;
      ST_DATA: if (sd_clk_en_i && r_cnt == LenWidth'(1)) w_next = ST_CRC;
      ST_CRC:  if (w_last_crc) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (abort_i) w_next = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_act   <= '0;
      r_crc   <= '0;
      r_err   <= '0;
      r_ok    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == ST_DONE);
      // Abort freezes results exactly where they were.
      if (!abort_i) begin
        case (r_state)
          ST_IDLE: begin
            if (start_i) begin
              r_crc <= '0;
              r_err <= '0;
              r_ok  <= 1'b0;
              r_act <= w_act_mask;
              r_cnt <= block_len_i;
              r_idx <= 4'd15;
            end
          end
          ST_DATA: begin
            if (sd_clk_en_i) begin
              for (int l = 0; l < NumLanes; l++) begin
                if (r_act[l]) r_crc[l] <= f_crc_step(r_crc[l], dat_i[l]);
              end
              r_cnt <= r_cnt - LenWidth'(1);
              r_idx <= 4'd15;
            end
          end
          ST_CRC: begin
            if (sd_clk_en_i) begin
              r_err <= r_err | w_bit_err;
              r_idx <= r_idx - 4'd1;
              // Final verdict must already be visible in the done cycle.
              if (w_last_crc) r_ok <= ~|(r_err | w_bit_err);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_o    = (r_state == ST_DATA) || (r_state == ST_CRC);
  assign done_o    = r_done;
  assign crc_ok_o  = r_ok;
  assign crc_err_o = r_err;
  assign crc_o     = r_crc;

endmodule
